// File: rtl/paralelo_serial_param.sv
// Parameterised MSB-first parallel-to-serial converter with idle-word filler.
// Define PS_UNDERRUN_EN to add the sticky underrun_out flag.
module paralelo_serial_param #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             active,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             idle_out
`ifdef PS_UNDERRUN_EN
    ,
    output logic             underrun_out
`endif
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift, shift_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             idle_nxt;
    logic             boundary;

    assign boundary  = (cnt == LAST);
    assign ready_out = boundary && active;
    assign data_out  = shift[WIDTH-1];

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            cnt      <= LAST;
            idle_out <= 1'b1;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            cnt      <= cnt_nxt;
            idle_out <= idle_nxt;
        end
    end

    // active/valid_in only matter on the boundary cycle; mid-word just shifts
    always_comb begin
        state_nxt = state;
        shift_nxt = shift << 1;
        cnt_nxt   = cnt + 1'b1;
        idle_nxt  = idle_out;
        if (boundary) begin
            cnt_nxt = '0;
            if (active && valid_in) begin
                shift_nxt = data_in;
                idle_nxt  = 1'b0;
                state_nxt = S_ACTIVE;
            end else begin
                shift_nxt = IDLE_WORD;
                idle_nxt  = 1'b1;
                state_nxt = active ? S_ACTIVE : S_IDLE;
            end
        end
    end

`ifdef PS_UNDERRUN_EN
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset)
            underrun_out <= 1'b0;
        else if (boundary && (state == S_ACTIVE) && active && !valid_in)
            underrun_out <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: WIDTH=8 and WIDTH=10 instances checked
// against a word-level reference model, directed scenarios plus random traffic.
module tb_paralelo_serial_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        act [2];
    logic        val [2];
    logic [31:0] din [2];

    logic       act8, val8, rdy8, dout8, idle8;
    logic [7:0] din8;
    logic       act10, val10, rdy10, dout10, idle10;
    logic [9:0] din10;
    logic       und8, und10;

    assign act8  = act[0];
    assign val8  = val[0];
    assign din8  = din[0][7:0];
    assign act10 = act[1];
    assign val10 = val[1];
    assign din10 = din[1][9:0];

    paralelo_serial_param #(.WIDTH(8), .IDLE_WORD(8'hBC)) dut8 (
        .clk_32f(clk), .reset(reset), .active(act8), .data_in(din8),
        .valid_in(val8), .ready_out(rdy8), .data_out(dout8), .idle_out(idle8)
`ifdef PS_UNDERRUN_EN
        , .underrun_out(und8)
`endif
    );

    paralelo_serial_param #(.WIDTH(10), .IDLE_WORD(10'h17C)) dut10 (
        .clk_32f(clk), .reset(reset), .active(act10), .data_in(din10),
        .valid_in(val10), .ready_out(rdy10), .data_out(dout10), .idle_out(idle10)
`ifdef PS_UNDERRUN_EN
        , .underrun_out(und10)
`endif
    );

`ifndef PS_UNDERRUN_EN
    assign und8  = 1'b0;
    assign und10 = 1'b0;
`endif

    // reference model: current word, bits already sent, link flag, underrun flag
    int          W  [2] = '{8, 10};
    logic [31:0] IW [2] = '{32'hBC, 32'h17C};
    logic [31:0] m_word [2];
    int          m_pos  [2];
    logic        m_idle [2];
    logic        m_link [2];
    logic        m_und  [2];
    logic        acc    [2];
    logic [31:0] cap    [2];
    int          rdy_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_word[k] = '0;
            m_pos[k]  = W[k] - 1;
            m_idle[k] = 1'b1;
            m_link[k] = 1'b0;
            m_und[k]  = 1'b0;
            acc[k]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            acc[k] = 1'b0;
            if (reset) begin
                model_reset();
            end else if (m_pos[k] == W[k] - 1) begin
                m_pos[k] = 0;
                if (act[k] && val[k]) begin
                    m_word[k] = din[k];
                    m_idle[k] = 1'b0;
                    m_link[k] = 1'b1;
                    acc[k]    = 1'b1;
                end else begin
                    if (act[k] && m_link[k]) m_und[k] = 1'b1;
                    m_word[k] = IW[k];
                    m_idle[k] = 1'b1;
                    m_link[k] = act[k];
                end
            end else begin
                m_pos[k]++;
            end
        end
    endtask

    function automatic logic exp_bit(input int k);
        return m_word[k][W[k] - 1 - m_pos[k]];
    endfunction

    function automatic logic exp_rdy(input int k);
        return (m_pos[k] == W[k] - 1) && act[k] && !reset;
    endfunction

    task automatic check_regs();
        chk("dout8", 32'(dout8), 32'(exp_bit(0)));
        chk("idle8", 32'(idle8), 32'(m_idle[0]));
        chk("dout10", 32'(dout10), 32'(exp_bit(1)));
        chk("idle10", 32'(idle10), 32'(m_idle[1]));
`ifdef PS_UNDERRUN_EN
        chk("und8", 32'(und8), 32'(m_und[0]));
        chk("und10", 32'(und10), 32'(m_und[1]));
`endif
    endtask

    // inputs are set just after a negedge; sample ready, clock, sample registers
    task automatic cycle();
        #1;
        chk("rdy8", 32'(rdy8), 32'(exp_rdy(0)));
        chk("rdy10", 32'(rdy10), 32'(exp_rdy(1)));
        if (rdy8) rdy_cnt++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
        cap[0] = {cap[0][30:0], dout8};
        cap[1] = {cap[1][30:0], dout10};
    endtask

    task automatic gen(input int k);
        if (acc[k] || !val[k]) begin
            val[k] = ($urandom_range(3) != 0);
            din[k] = $urandom & ((32'd1 << W[k]) - 1);
        end
        if ($urandom_range(15) == 0) act[k] = !act[k];
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; val[k] = 1'b0; din[k] = '0; cap[k] = '0;
        end
        model_reset();
        #1;
        chk("rst_dout8", 32'(dout8), 32'd0);
        chk("rst_idle8", 32'(idle8), 32'd1);
        chk("rst_und8", 32'(und8), 32'd0);
        @(negedge clk);
        repeat (3) cycle();

        // idle stream with link down
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (8) cycle();
        chk("idle_word", cap[0] & 32'hFF, 32'hBC);
        repeat (8) cycle();
        chk("idle_word2", cap[0] & 32'hFF, 32'hBC);
        chk("idle_rdy", 32'(rdy_cnt), 32'd0);

        // single handshake
        act[0] = 1'b1; val[0] = 1'b1; din[0] = 32'hA5;
        rdy_cnt = 0;
        repeat (8) cycle();
        chk("word_a5", cap[0] & 32'hFF, 32'hA5);
        chk("rdy_once", 32'(rdy_cnt), 32'd1);

        // back-to-back, no filler between
        din[0] = 32'hFF;
        repeat (8) cycle();
        din[0] = 32'h00;
        repeat (8) cycle();
        chk("b2b", cap[0] & 32'hFFFF, 32'hFF00);

        // underrun inserts filler and the flag sticks
        val[0] = 1'b0;
        repeat (8) cycle();
        chk("underrun_fill", cap[0] & 32'hFF, 32'hBC);
`ifdef PS_UNDERRUN_EN
        chk("underrun_set", 32'(und8), 32'd1);
`endif
        val[0] = 1'b1; din[0] = 32'h5A;
        repeat (8) cycle();
        chk("word_5a", cap[0] & 32'hFF, 32'h5A);
`ifdef PS_UNDERRUN_EN
        chk("underrun_sticky", 32'(und8), 32'd1);
`endif

        // link drops mid-word; word completes, then filler with no ready
        din[0] = 32'h3C;
        repeat (4) cycle();
        act[0] = 1'b0; val[0] = 1'b0;
        repeat (4) cycle();
        chk("word_3c", cap[0] & 32'hFF, 32'h3C);
        rdy_cnt = 0;
        repeat (8) cycle();
        chk("drop_fill", cap[0] & 32'hFF, 32'hBC);
        chk("drop_rdy", 32'(rdy_cnt), 32'd0);

        // random traffic on both instances
        acc[0] = 1'b1; acc[1] = 1'b1;
        repeat (600) begin
            gen(0);
            gen(1);
            cycle();
        end

        // reset mid-word on the 10-bit instance
        act[1] = 1'b0; val[1] = 1'b0;
        begin
            int guard = 0;
            while (m_pos[1] != 5 && guard < 20) begin
                cycle();
                guard++;
            end
            chk("sync10", 32'(m_pos[1]), 32'd5);
        end
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst10_dout", 32'(dout10), 32'd0);
        chk("rst10_idle", 32'(idle10), 32'd1);
        chk("rst10_und", 32'(und10), 32'd0);
        chk("rst10_rdy", 32'(rdy10), 32'd0);
        repeat (2) cycle();
        reset = 1'b0;
        act[0] = 1'b0; val[0] = 1'b0;
        repeat (10) cycle();
        chk("idle10_a", cap[1] & 32'h3FF, 32'h17C);
        repeat (10) cycle();
        chk("idle10_b", cap[1] & 32'h3FF, 32'h17C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
